// File: rtl/layer_bg.sv
// layer_bg: programmable background layer for the video pipeline.
// Renders one of four patterns (solid, checkerboard, 8 colour bars, horizontal
// gradient) with optional per-frame horizontal scroll. Configuration writes go
// to a pending bank and are promoted to the active bank only at a frame
// boundary, so a frame is always drawn with a single configuration.
//
// Ports:
//   clk, rstb                 pixel clock, asynchronous active-low reset
//   h_c_en, v_c, h_c          active-video qualifier and raster counters
//   cfg_wr                    one-cycle strobe loading cfg_* into the pending bank
//   cfg_mode                  0 solid, 1 checker, 2 bars, 3 gradient
//   cfg_col_a, cfg_col_b      colours A and B, packed {r,g,b}
//   cfg_scroll                scroll by 1 px per frame when active
//   cfg_pend                  pending configuration not yet applied
//   gen_da_en, gen_da_r/g/b   pixel valid and colour, 2 clocks after the counters
module layer_bg #(
    parameter int unsigned CW        = 8,
    parameter int unsigned HW        = 10,
    parameter int unsigned CELL_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            h_c_en,
    input  logic [HW-1:0]   v_c,
    input  logic [HW-1:0]   h_c,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_mode,
    input  logic [3*CW-1:0] cfg_col_a,
    input  logic [3*CW-1:0] cfg_col_b,
    input  logic            cfg_scroll,
    output logic            cfg_pend,
    output logic            gen_da_en,
    output logic [CW-1:0]   gen_da_r,
    output logic [CW-1:0]   gen_da_g,
    output logic [CW-1:0]   gen_da_b
);

    typedef enum logic [1:0] {
        ModeSolid   = 2'd0,
        ModeChecker = 2'd1,
        ModeBars    = 2'd2,
        ModeGrad    = 2'd3
    } mode_e;

    localparam logic [3*CW-1:0] COL_A_RST = {CW'(64), CW'(64), CW'(128)};

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    // Frame boundary detection
    logic [HW-1:0] r_v_c_d;
    logic          w_fb;

    assign w_fb = (v_c == '0) && (r_v_c_d != '0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_v_c_d <= '0;
        end else begin
            r_v_c_d <= v_c;
        end
    end

    // Pending / active configuration banks
    mode_e         r_pend_mode,  r_act_mode;
    logic [3*CW-1:0] r_pend_col_a, r_act_col_a;
    logic [3*CW-1:0] r_pend_col_b, r_act_col_b;
    logic          r_pend_scroll, r_act_scroll;
    logic          r_cfg_pend;
    logic [HW-1:0] r_offset;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pend_mode   <= ModeSolid;
            r_pend_col_a  <= COL_A_RST;
            r_pend_col_b  <= '0;
            r_pend_scroll <= 1'b0;
            r_cfg_pend    <= 1'b0;
        end else if (cfg_wr) begin
            // A write in the fb cycle still wins: it becomes the new pending set
            r_pend_mode   <= mode_e'(cfg_mode);
            r_pend_col_a  <= cfg_col_a;
            r_pend_col_b  <= cfg_col_b;
            r_pend_scroll <= cfg_scroll;
            r_cfg_pend    <= 1'b1;
        end else if (w_fb) begin
            r_cfg_pend    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_act_mode   <= ModeSolid;
            r_act_col_a  <= COL_A_RST;
            r_act_col_b  <= '0;
            r_act_scroll <= 1'b0;
        end else if (w_fb && r_cfg_pend) begin
            // Non-blocking reads give the pending set from before any same-cycle write
            r_act_mode   <= r_pend_mode;
            r_act_col_a  <= r_pend_col_a;
            r_act_col_b  <= r_pend_col_b;
            r_act_scroll <= r_pend_scroll;
        end
    end

    // Scroll offset advances on the scroll bit that was active during the frame
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_offset <= '0;
        end else if (w_fb && r_act_scroll) begin
            r_offset <= r_offset + HW'(1);
        end
    end

    assign cfg_pend = r_cfg_pend;

    // Stage 1: scrolled coordinates plus a snapshot of the active configuration,
    // so a pixel is coloured entirely with the config it was captured under.
    logic [HW-1:0]   w_x;
    logic            r_s1_en;
    logic [HW-1:0]   r_s1_x;
    logic            r_s1_ysel;
    mode_e           r_s1_mode;
    logic [3*CW-1:0] r_s1_col_a;
    logic [3*CW-1:0] r_s1_col_b;

    assign w_x = h_c + r_offset;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_s1_en    <= 1'b0;
            r_s1_x     <= '0;
            r_s1_ysel  <= 1'b0;
            r_s1_mode  <= ModeSolid;
            r_s1_col_a <= '0;
            r_s1_col_b <= '0;
        end else begin
            r_s1_en    <= h_c_en;
            r_s1_x     <= w_x;
            r_s1_ysel  <= v_c[CELL_LOG2];
            r_s1_mode  <= r_act_mode;
            r_s1_col_a <= r_act_col_a;
            r_s1_col_b <= r_act_col_b;
        end
    end

    // Pattern generation
    logic [CW-1:0] w_ca_r, w_ca_g, w_ca_b;
    logic [CW-1:0] w_cb_r, w_cb_g, w_cb_b;
    logic          w_sel;
    logic [2:0]    w_bar;
    logic [CW-1:0] w_t;
    logic [CW-1:0] w_out_r, w_out_g, w_out_b;
    logic          w_unused_x;

    assign w_ca_r = r_s1_col_a[3*CW-1 -: CW];
    assign w_ca_g = r_s1_col_a[2*CW-1 -: CW];
    assign w_ca_b = r_s1_col_a[CW-1:0];
    assign w_cb_r = r_s1_col_b[3*CW-1 -: CW];
    assign w_cb_g = r_s1_col_b[2*CW-1 -: CW];
    assign w_cb_b = r_s1_col_b[CW-1:0];

    assign w_sel      = r_s1_x[CELL_LOG2] ^ r_s1_ysel;
    assign w_bar      = r_s1_x[HW-1 -: 3];
    assign w_t        = r_s1_x[HW-1 -: CW];
    // Low x bits only matter for some parameter sets
    assign w_unused_x = ^r_s1_x;

    always_comb begin
        w_out_r = w_ca_r;
        w_out_g = w_ca_g;
        w_out_b = w_ca_b;
        unique case (r_s1_mode)
            ModeSolid: begin
            end
            ModeChecker: begin
                if (w_sel) begin
                    w_out_r = w_cb_r;
                    w_out_g = w_cb_g;
                    w_out_b = w_cb_b;
                end
            end
            ModeBars: begin
                w_out_r = w_bar[2] ? w_ca_r : w_cb_r;
                w_out_g = w_bar[1] ? w_ca_g : w_cb_g;
                w_out_b = w_bar[0] ? w_ca_b : w_cb_b;
            end
            ModeGrad: begin
                w_out_r = sat_add(w_ca_r, w_t);
                w_out_g = sat_add(w_ca_g, w_t);
                w_out_b = sat_add(w_ca_b, w_t);
            end
        endcase
    end

    // Stage 2: registered outputs, forced to zero during blanking
    logic          r_en;
    logic [CW-1:0] r_r, r_g, r_b;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_en <= 1'b0;
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
        end else if (r_s1_en) begin
            r_en <= 1'b1;
            r_r  <= w_out_r;
            r_g  <= w_out_g;
            r_b  <= w_out_b;
        end else begin
            r_en <= 1'b0;
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
        end
    end

    assign gen_da_en = r_en;
    assign gen_da_r  = r_r;
    assign gen_da_g  = r_g;
    assign gen_da_b  = r_b;

endmodule

// File: tb/tb_layer_bg.sv
module tb_layer_bg;

    localparam int CW = 8;
    localparam int HW = 10;
    localparam int CL = 5;
    localparam logic [23:0] DEF_A = 24'h404080;

    logic            clk = 1'b0;
    logic            rstb;
    logic            h_c_en;
    logic [HW-1:0]   v_c;
    logic [HW-1:0]   h_c;
    logic            cfg_wr;
    logic [1:0]      cfg_mode;
    logic [3*CW-1:0] cfg_col_a;
    logic [3*CW-1:0] cfg_col_b;
    logic            cfg_scroll;
    logic            cfg_pend;
    logic            gen_da_en;
    logic [CW-1:0]   gen_da_r;
    logic [CW-1:0]   gen_da_g;
    logic [CW-1:0]   gen_da_b;

    always #5 clk = ~clk;

    layer_bg #(
        .CW        (CW),
        .HW        (HW),
        .CELL_LOG2 (CL)
    ) u_dut (
        .clk        (clk),
        .rstb       (rstb),
        .h_c_en     (h_c_en),
        .v_c        (v_c),
        .h_c        (h_c),
        .cfg_wr     (cfg_wr),
        .cfg_mode   (cfg_mode),
        .cfg_col_a  (cfg_col_a),
        .cfg_col_b  (cfg_col_b),
        .cfg_scroll (cfg_scroll),
        .cfg_pend   (cfg_pend),
        .gen_da_en  (gen_da_en),
        .gen_da_r   (gen_da_r),
        .gen_da_g   (gen_da_g),
        .gen_da_b   (gen_da_b)
    );

    typedef struct {
        logic        chk;
        logic        en;
        logic [23:0] rgb;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic [23:0]   a;
        logic [23:0]   b;
        logic [HW-1:0] h;
        logic [HW-1:0] v;
        logic [23:0]   exp;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push_exp(input logic chk, input logic en, input logic [23:0] rgb,
                            input string name);
        exp_t e;
        e.chk  = chk;
        e.en   = en;
        e.rgb  = en ? rgb : 24'h0;
        e.name = name;
        sb.push_back(e);
    endtask

    // One pixel clock: compare the output due now (driven 2 clocks ago), then drive.
    task automatic step(input logic hen, input logic [HW-1:0] v, input logic [HW-1:0] h,
                        input logic wr, input logic chk, input logic [23:0] rgb,
                        input string name);
        exp_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                n_checks++;
                if ({gen_da_en, gen_da_r, gen_da_g, gen_da_b} !== {e.en, e.rgb}) begin
                    n_errors++;
                    $display("FAIL %s: got en=%0b rgb=%06h, expected en=%0b rgb=%06h",
                             e.name, gen_da_en, {gen_da_r, gen_da_g, gen_da_b}, e.en, e.rgb);
                end
            end
        end
        h_c_en = hen;
        v_c    = v;
        h_c    = h;
        cfg_wr = wr;
        push_exp(chk, hen, rgb, name);
    endtask

    task automatic check_pend(input logic exp, input string name);
        n_checks++;
        if (cfg_pend !== exp) begin
            n_errors++;
            $display("FAIL %s: got cfg_pend=%0b, expected %0b", name, cfg_pend, exp);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({gen_da_en, gen_da_r, gen_da_g, gen_da_b} !== 25'h0) begin
            n_errors++;
            $display("FAIL %s: got en=%0b rgb=%06h, expected en=0 rgb=000000",
                     name, gen_da_en, {gen_da_r, gen_da_g, gen_da_b});
        end
    endtask

    // Release reset on a negedge; the release-time inputs act as a normal drive slot.
    task automatic release_reset(input logic hen, input logic [HW-1:0] v,
                                 input logic [HW-1:0] h, input logic [23:0] rgb,
                                 input string name);
        @(negedge clk);
        sb.delete();
        push_exp(1'b1, 1'b0, 24'h0, "reset_hold");
        rstb   = 1'b1;
        h_c_en = hen;
        v_c    = v;
        h_c    = h;
        cfg_wr = 1'b0;
        push_exp(1'b1, hen, rgb, name);
    endtask

    task automatic fb_only();
        step(1'b0, 10'd1, 10'd0, 1'b0, 1'b0, 24'h0, "pre_fb");
        step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 24'h0, "fb");
    endtask

    task automatic apply_cfg(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b,
                             input logic s);
        cfg_mode   = m;
        cfg_col_a  = a;
        cfg_col_b  = b;
        cfg_scroll = s;
        step(1'b0, 10'd1, 10'd0, 1'b1, 1'b0, 24'h0, "cfg_wr");
        fb_only();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd0,    10'd1,  24'h000000};
        tbl[1]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd127,  10'd1,  24'h000000};
        tbl[2]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd128,  10'd1,  24'h0000FF};
        tbl[3]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd384,  10'd1,  24'h00FFFF};
        tbl[4]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd511,  10'd1,  24'h00FFFF};
        tbl[5]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd640,  10'd1,  24'hFF00FF};
        tbl[6]  = '{2'd2, 24'hFFFFFF, 24'h000000, 10'd1023, 10'd1,  24'hFFFFFF};
        tbl[7]  = '{2'd3, 24'hC80010, 24'h123456, 10'd40,   10'd1,  24'hD20A1A};
        tbl[8]  = '{2'd3, 24'hC80010, 24'h123456, 10'd220,  10'd1,  24'hFF3747};
        tbl[9]  = '{2'd3, 24'hC80010, 24'h123456, 10'd300,  10'd1,  24'hFF4B5B};
        tbl[10] = '{2'd3, 24'hC80010, 24'h123456, 10'd0,    10'd1,  24'hC80010};
        tbl[11] = '{2'd3, 24'hC80010, 24'h123456, 10'd1023, 10'd1,  24'hFFFFFF};
        tbl[12] = '{2'd0, 24'h112233, 24'h445566, 10'd500,  10'd7,  24'h112233};
        tbl[13] = '{2'd1, 24'h010203, 24'hA0B0C0, 10'd31,   10'd0,  24'h010203};
        tbl[14] = '{2'd1, 24'h010203, 24'hA0B0C0, 10'd32,   10'd0,  24'hA0B0C0};
        tbl[15] = '{2'd1, 24'h010203, 24'hA0B0C0, 10'd32,   10'd32, 24'h010203};
        tbl[16] = '{2'd1, 24'h010203, 24'hA0B0C0, 10'd0,    10'd32, 24'hA0B0C0};
        tbl[17] = '{2'd1, 24'h010203, 24'hA0B0C0, 10'd64,   10'd96, 24'hA0B0C0};

        rstb       = 1'b0;
        h_c_en     = 1'b0;
        v_c        = '0;
        h_c        = '0;
        cfg_wr     = 1'b0;
        cfg_mode   = '0;
        cfg_col_a  = '0;
        cfg_col_b  = '0;
        cfg_scroll = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        check_pend(1'b0, "reset_pend");
        release_reset(1'b0, 10'd1, 10'd0, 24'h0, "blank0");
        step(1'b0, 10'd1, 10'd1, 1'b0, 1'b1, 24'h0, "blank1");

        // Default solid colour, exactly 2 clocks after h_c_en rises
        step(1'b1, 10'd1, 10'd2, 1'b0, 1'b1, DEF_A, "solid_first");
        step(1'b1, 10'd1, 10'd3, 1'b0, 1'b1, DEF_A, "solid_second");
        step(1'b0, 10'd1, 10'd4, 1'b0, 1'b1, 24'h0, "blank_mid");

        // Mid-frame write holds until the next frame boundary
        cfg_mode   = 2'd1;
        cfg_col_a  = 24'h000000;
        cfg_col_b  = 24'hFFFFFF;
        cfg_scroll = 1'b0;
        step(1'b1, 10'd1, 10'd100, 1'b1, 1'b1, DEF_A, "old_persist0");
        check_pend(1'b0, "pend_before_rise");
        step(1'b1, 10'd1, 10'd101, 1'b0, 1'b1, DEF_A, "old_persist1");
        check_pend(1'b1, "pend_rise");
        step(1'b1, 10'd1, 10'd102, 1'b0, 1'b1, DEF_A, "old_persist2");
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 24'h0, "fb_pixel");
        check_pend(1'b1, "pend_at_fb");
        step(1'b1, 10'd0, 10'd32, 1'b0, 1'b1, 24'hFFFFFF, "chk_v0_h32");
        check_pend(1'b0, "pend_fall");
        step(1'b1, 10'd32, 10'd32, 1'b0, 1'b1, 24'h000000, "chk_v32_h32");

        // Pattern vectors
        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i].mode != cfg_mode || tbl[i].a != cfg_col_a ||
                tbl[i].b != cfg_col_b) begin
                apply_cfg(tbl[i].mode, tbl[i].a, tbl[i].b, 1'b0);
            end
            step(1'b1, tbl[i].v, tbl[i].h, 1'b0, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Scroll: enabled at first fb, then advances once per later fb
        apply_cfg(2'd1, 24'h000000, 24'hFFFFFF, 1'b1);
        repeat (3) fb_only();
        step(1'b1, 10'd0, 10'd29, 1'b0, 1'b1, 24'hFFFFFF, "scroll3_h29");
        step(1'b1, 10'd0, 10'd28, 1'b0, 1'b1, 24'h000000, "scroll3_h28");
        repeat (1020) fb_only();
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 24'hFFFFFF, "off1023_h0");
        step(1'b1, 10'd0, 10'd1, 1'b0, 1'b1, 24'h000000, "off1023_h1");
        fb_only();
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 24'h000000, "wrap_h0");
        step(1'b1, 10'd0, 10'd32, 1'b0, 1'b1, 24'hFFFFFF, "wrap_h32");
        // Disabling: the fb that applies it still advances (0 -> 1), then it holds
        apply_cfg(2'd1, 24'h000000, 24'hFFFFFF, 1'b0);
        step(1'b1, 10'd0, 10'd31, 1'b0, 1'b1, 24'hFFFFFF, "dis_h31");
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 24'h000000, "dis_h0");
        fb_only();
        step(1'b1, 10'd0, 10'd31, 1'b0, 1'b1, 24'hFFFFFF, "hold_h31");
        step(1'b1, 10'd0, 10'd30, 1'b0, 1'b1, 24'h000000, "hold_h30");

        // cfg_wr on the fb cycle with a pending config
        cfg_mode   = 2'd0;
        cfg_col_a  = 24'h0A0B0C;
        cfg_col_b  = 24'h000000;
        cfg_scroll = 1'b0;
        step(1'b1, 10'd1, 10'd5, 1'b1, 1'b0, 24'h0, "sc_wr1");
        step(1'b1, 10'd1, 10'd6, 1'b0, 1'b0, 24'h0, "sc_idle");
        check_pend(1'b1, "sc_pend1");
        cfg_col_a = 24'h505050;
        step(1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 24'h0, "sc_fb_wr");
        step(1'b1, 10'd0, 10'd5, 1'b0, 1'b1, 24'h0A0B0C, "sc_old_applied");
        check_pend(1'b1, "sc_pend_kept");
        fb_only();
        step(1'b1, 10'd0, 10'd5, 1'b0, 1'b1, 24'h505050, "sc_new_applied");
        check_pend(1'b0, "sc_pend_clr");
        // cfg_wr on the fb cycle without a pending config: active is untouched
        cfg_col_a = 24'h777777;
        step(1'b1, 10'd1, 10'd0, 1'b0, 1'b0, 24'h0, "sc_pre_fb");
        step(1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 24'h0, "sc_fb_wr_nopend");
        step(1'b1, 10'd0, 10'd5, 1'b0, 1'b1, 24'h505050, "sc_nopend_hold");
        check_pend(1'b1, "sc_nopend_pend");
        fb_only();
        step(1'b1, 10'd0, 10'd5, 1'b0, 1'b1, 24'h777777, "sc_late_apply");

        // Mid-frame asynchronous reset with a pending write outstanding
        cfg_mode = 2'd2;
        step(1'b1, 10'd3, 10'd10, 1'b1, 1'b0, 24'h0, "pre_rst0");
        step(1'b1, 10'd3, 10'd11, 1'b0, 1'b0, 24'h0, "pre_rst1");
        check_pend(1'b1, "pend_pre_rst");
        #2 rstb = 1'b0;
        #1;
        check_zero("async_rst_outputs");
        check_pend(1'b0, "async_rst_pend");
        release_reset(1'b1, 10'd3, 10'd0, DEF_A, "rst_first");
        step(1'b1, 10'd3, 10'd1, 1'b0, 1'b1, DEF_A, "rst_second");
        step(1'b0, 10'd3, 10'd2, 1'b0, 1'b0, 24'h0, "drain0");
        step(1'b0, 10'd3, 10'd3, 1'b0, 1'b0, 24'h0, "drain1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
